// File: rtl/bnn_pkg.sv
// -----------------------------------------------------------------------------
// bnn_pkg
// Shared definitions for the BPU group and its downstream consumers.
//   CH       : channels per output pixel (one BPU popcount per channel)
//   PW       : popcount width, signed two's complement
//   popcnt_t     : one signed popcount
//   popcnt_vec_t : one beat of CH popcounts, channel c in entry [c]
//   bin_bit  : folded batch-norm binarization of one channel
// -----------------------------------------------------------------------------
package bnn_pkg;

    localparam int CH    = 8;
    localparam int PW    = 7;
    localparam int SEL_W = $clog2(CH);

    typedef logic signed [PW-1:0] popcnt_t;
    typedef popcnt_t [CH-1:0]     popcnt_vec_t;

    // Both operands are popcnt_t, so the compare stays a signed PW-bit
    // compare with no widening; equality gives 1 before the polarity flip.
    function automatic logic bin_bit(input popcnt_t value,
                                     input popcnt_t thr,
                                     input logic    flip);
        return (value >= thr) ^ flip;
    endfunction

endpackage

// File: rtl/bnn_act_pool_if.sv
// -----------------------------------------------------------------------------
// bnn_act_pool_if
// Bundles the beat input, threshold-load, mode control and output FIFO
// handshake of bnn_act_pool.
//   master : sequencer / write-back side (drives beats, controls, out_ready)
//   slave  : bnn_act_pool (drives in_ready, out_valid, out_data, out_count)
// -----------------------------------------------------------------------------
interface bnn_act_pool_if #(
    parameter int DEPTH = 4
) ();

    localparam int CW = $clog2(DEPTH) + 1;

    logic                             in_valid;
    logic                             in_ready;
    bnn_pkg::popcnt_vec_t             bpu_out;
    logic                             thr_load;
    logic [bnn_pkg::SEL_W-1:0]        thr_sel;
    bnn_pkg::popcnt_t                 thr_data;
    logic                             flip_data;
    logic                             pool_en;
    logic                             pool_clr;
    logic                             out_valid;
    logic                             out_ready;
    logic [7:0]                       out_data;
    logic [CW-1:0]                    out_count;

    modport master (
        output in_valid, bpu_out, thr_load, thr_sel, thr_data, flip_data,
               pool_en, pool_clr, out_ready,
        input  in_ready, out_valid, out_data, out_count
    );

    modport slave (
        input  in_valid, bpu_out, thr_load, thr_sel, thr_data, flip_data,
               pool_en, pool_clr, out_ready,
        output in_ready, out_valid, out_data, out_count
    );

endinterface

// File: rtl/bnn_sync_fifo.sv
// -----------------------------------------------------------------------------
// bnn_sync_fifo
// Single-clock FIFO with registered storage and occupancy count.
//   clk, rst  : clock, synchronous active-high reset (clears memory too,
//               so the head reads 0 after reset)
//   i_push    : write i_data (caller guarantees not full)
//   i_pop     : drop head entry; ignored when empty
//   o_data    : head entry, mem[rd_ptr]
//   o_count   : occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module bnn_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_pop;

    assign w_pop   = i_pop & (r_count != {CW{1'b0}});
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Storage, pointers and occupancy; pointers wrap since DEPTH is 2^AW.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/bnn_act_pool.sv
// -----------------------------------------------------------------------------
// bnn_act_pool
// Binarizes 8 signed popcounts per beat against per-channel thresholds with
// optional polarity flip, optionally OR-pools 4 beats (2x2 binary max-pool),
// and queues the packed byte in a small FIFO.
//   clk_bpug : gated BPU-group clock, all state here
//   rst      : synchronous active-high reset
//   bus      : bnn_act_pool_if.slave (beats, threshold load, pool control,
//              output FIFO handshake and occupancy)
// -----------------------------------------------------------------------------
module bnn_act_pool
    import bnn_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk_bpug,
    input  logic               rst,
    bnn_act_pool_if.slave      bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    popcnt_t       r_thr  [CH];
    logic [CH-1:0] r_flip;
    logic [CH-1:0] r_acc;
    logic [1:0]    r_pcnt;

    logic          w_accept;
    logic [CH-1:0] w_bits;
    logic [CH-1:0] w_merged;
    logic          w_push;
    logic [CW-1:0] w_count;
    logic [7:0]    w_head;

    // Full blocks every beat, including pool beats that would not push.
    assign bus.in_ready  = (w_count < CW'(DEPTH));
    assign w_accept      = bus.in_valid & bus.in_ready;
    assign w_merged      = r_acc | w_bits;
    assign bus.out_valid = (w_count != {CW{1'b0}});
    assign bus.out_data  = w_head;
    assign bus.out_count = w_count;

    // Per-channel binarization with the thresholds held before this edge.
    always_comb begin
        w_bits = {CH{1'b0}};
        for (int c = 0; c < CH; c++) begin
            w_bits[c] = bin_bit(bus.bpu_out[c], r_thr[c], r_flip[c]);
        end
    end

    // Push decision; pass-through also flushes a leftover partial window.
    always_comb begin
        w_push = 1'b0;
        if (w_accept && !bus.pool_clr) begin
            if (!bus.pool_en) begin
                w_push = 1'b1;
            end else if (r_pcnt == 2'd3) begin
                w_push = 1'b1;
            end else begin
                w_push = 1'b0;
            end
        end else begin
            w_push = 1'b0;
        end
    end

    // Threshold and polarity bank.
    always_ff @(posedge clk_bpug) begin
        if (rst) begin
            for (int c = 0; c < CH; c++) begin
                r_thr[c] <= popcnt_t'(0);
            end
            r_flip <= {CH{1'b0}};
        end else if (bus.thr_load) begin
            r_thr[bus.thr_sel]  <= bus.thr_data;
            r_flip[bus.thr_sel] <= bus.flip_data;
        end else begin
            r_flip <= r_flip;
        end
    end

    // Pool window accumulator; pool_clr beats any accepted beat.
    always_ff @(posedge clk_bpug) begin
        if (rst || bus.pool_clr) begin
            r_acc  <= {CH{1'b0}};
            r_pcnt <= 2'd0;
        end else if (w_accept) begin
            if (!bus.pool_en || (r_pcnt == 2'd3)) begin
                r_acc  <= {CH{1'b0}};
                r_pcnt <= 2'd0;
            end else begin
                r_acc  <= w_merged;
                r_pcnt <= r_pcnt + 2'd1;
            end
        end else begin
            r_acc  <= r_acc;
            r_pcnt <= r_pcnt;
        end
    end

    bnn_sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk_bpug),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_merged),
        .i_pop   (bus.out_ready),
        .o_data  (w_head),
        .o_count (w_count)
    );

endmodule
